// File: rtl/zero_io_pkg.sv
// Shared types and helpers for the zero VM input/output channel unit.
package zero_io_pkg;

   localparam int DEFAULT_WIDTH = 12;

   typedef enum logic [1:0] {
      OP_NOP    = 2'd0,
      OP_IN     = 2'd1,
      OP_INSIZE = 2'd2,
      OP_OUT    = 2'd3
   } op_code_e;

   typedef enum logic [1:0] {
      CH_EMPTY   = 2'd0,
      CH_PARTIAL = 2'd1,
      CH_FULL    = 2'd2
   } chan_state_e;

   // Index width that never collapses to zero bits for a single-entry range.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/zero_in_fifo.sv
// One input channel: synchronous FIFO with occupancy count and a
// simultaneous push/pop path. Full/empty come from a small state register
// that always mirrors the count.
//
//   state      | meaning
//   -----------+------------------------------------------
//   CH_EMPTY   | count == 0, pops are refused
//   CH_PARTIAL | 0 < count < NIN, push and pop both accepted
//   CH_FULL    | count == NIN, pushes are refused
module zero_in_fifo
   import zero_io_pkg::*;
#(
   parameter  int WIDTH = DEFAULT_WIDTH,
   parameter  int NIN   = 8,
   localparam int PW    = clog2_min1(NIN),
   localparam int CNTW  = $clog2(NIN + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CNTW-1:0]  count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [NIN];
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [PW-1:0]    wptr_q, wptr_d;
   logic [CNTW-1:0]  count_q, count_d;
   chan_state_e      state_q, state_d;
   logic             do_push, do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(NIN - 1)) ? '0 : p + 1'b1;
   endfunction

   // Accept/refuse decisions use the pre-cycle state; pointers, count and state follow.
   always_comb begin
      do_push = push && (state_q != CH_FULL);
      do_pop  = pop  && (state_q != CH_EMPTY);
      rptr_d  = do_pop  ? ptr_inc(rptr_q) : rptr_q;
      wptr_d  = do_push ? ptr_inc(wptr_q) : wptr_q;
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (count_d == '0) begin
         state_d = CH_EMPTY;
      end else if (count_d == CNTW'(NIN)) begin
         state_d = CH_FULL;
      end else begin
         state_d = CH_PARTIAL;
      end
   end

   // Pointer, count and state registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
         state_q <= CH_EMPTY;
      end else begin
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
         state_q <= state_d;
      end
   end

   // Storage is left uninitialised; only the pointers define what is valid.
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem_q[wptr_q] <= push_data;
      end
   end

   assign head  = mem_q[rptr_q];
   assign count = count_q;
   assign full  = (state_q == CH_FULL);
   assign empty = (state_q == CH_EMPTY);

endmodule

// File: rtl/zero_io_channels.sv
// I/O channel unit for the zero VM: NCHAN harness-loaded input FIFOs and a
// wrap-around output ring with read-back. CPU ops complete in one cycle.
module zero_io_channels
   import zero_io_pkg::*;
#(
   parameter  int WIDTH = DEFAULT_WIDTH,
   parameter  int NCHAN = 2,
   parameter  int NIN   = 8,
   parameter  int NOUT  = 100,
   localparam int CW    = clog2_min1(NCHAN),
   localparam int AW    = $clog2(NOUT),
   localparam int OCW   = $clog2(NOUT + 1),
   localparam int CNTW  = $clog2(NIN + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load_valid,
   input  logic [CW-1:0]    load_chan,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   input  logic             op_valid,
   input  logic [1:0]       op_code,
   input  logic [CW-1:0]    op_chan,
   input  logic [WIDTH-1:0] op_data,
   output logic             res_valid,
   output logic [WIDTH-1:0] res_data,
   output logic             res_underflow,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data,
   output logic [OCW-1:0]   out_count,
   output logic             out_wrapped
);

   logic [WIDTH-1:0] fifo_head  [NCHAN];
   logic [CNTW-1:0]  fifo_count [NCHAN];
   logic [NCHAN-1:0] fifo_full, fifo_empty, push, pop;

   logic [WIDTH-1:0] sel_head;
   logic [CNTW-1:0]  sel_count;
   logic             sel_empty, op_chan_ok, load_full;

   logic [WIDTH-1:0] ring_q [NOUT];
   logic             ring_we;
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [OCW-1:0]   out_count_q, out_count_d;
   logic             out_wrapped_q, out_wrapped_d;
   logic             res_valid_q, res_valid_d;
   logic [WIDTH-1:0] res_data_q, res_data_d;
   logic             res_underflow_q, res_underflow_d;
   logic [WIDTH-1:0] rd_data_q, rd_data_d;

   // Reset suppresses every push/pop so a mid-sequence reset drops same-cycle traffic.
   for (genvar g = 0; g < NCHAN; g++) begin : g_chan
      assign push[g] = load_valid && !reset && (load_chan == CW'(g)) && !fifo_full[g];
      assign pop[g]  = op_valid && !reset && (op_code == OP_IN) && (op_chan == CW'(g));

      zero_in_fifo #(
         .WIDTH (WIDTH),
         .NIN   (NIN)
      ) u_fifo (
         .clock     (clock),
         .reset     (reset),
         .push      (push[g]),
         .push_data (load_data),
         .pop       (pop[g]),
         .head      (fifo_head[g]),
         .count     (fifo_count[g]),
         .full      (fifo_full[g]),
         .empty     (fifo_empty[g])
      );
   end

   // Channel selection; an unmatched channel looks empty to ops and full to loads.
   always_comb begin
      sel_head   = '0;
      sel_count  = '0;
      sel_empty  = 1'b1;
      op_chan_ok = 1'b0;
      load_full  = 1'b1;
      for (int i = 0; i < NCHAN; i++) begin
         if (op_chan == CW'(i)) begin
            sel_head   = fifo_head[i];
            sel_count  = fifo_count[i];
            sel_empty  = fifo_empty[i];
            op_chan_ok = 1'b1;
         end
         if (load_chan == CW'(i)) begin
            load_full = fifo_full[i];
         end
      end
   end

   assign load_ready = !load_full;

   // Op decode: IN/INSIZE results and OUT ring bookkeeping.
   always_comb begin
      res_valid_d     = 1'b0;
      res_data_d      = '0;
      res_underflow_d = 1'b0;
      ring_we         = 1'b0;
      wptr_d          = wptr_q;
      out_count_d     = out_count_q;
      out_wrapped_d   = out_wrapped_q;
      rd_data_d       = (rd_addr <= AW'(NOUT - 1)) ? ring_q[rd_addr] : '0;
      if (op_valid) begin
         case (op_code_e'(op_code))
            OP_IN: begin
               res_valid_d = 1'b1;
               if (!op_chan_ok || sel_empty) begin
                  res_underflow_d = 1'b1;
               end else begin
                  res_data_d = sel_head;
               end
            end
            OP_INSIZE: begin
               res_valid_d = 1'b1;
               if (!op_chan_ok) begin
                  res_underflow_d = 1'b1;
               end else begin
                  res_data_d = WIDTH'(sel_count);
               end
            end
            OP_OUT: begin
               ring_we = 1'b1;
               if (wptr_q == AW'(NOUT - 1)) begin
                  wptr_d        = '0;
                  out_wrapped_d = 1'b1;
               end else begin
                  wptr_d = wptr_q + 1'b1;
               end
               if (out_count_q != OCW'(NOUT)) begin
                  out_count_d = out_count_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Result, ring pointer and read-back registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         res_valid_q     <= 1'b0;
         res_data_q      <= '0;
         res_underflow_q <= 1'b0;
         wptr_q          <= '0;
         out_count_q     <= '0;
         out_wrapped_q   <= 1'b0;
         rd_data_q       <= '0;
      end else begin
         res_valid_q     <= res_valid_d;
         res_data_q      <= res_data_d;
         res_underflow_q <= res_underflow_d;
         wptr_q          <= wptr_d;
         out_count_q     <= out_count_d;
         out_wrapped_q   <= out_wrapped_d;
         rd_data_q       <= rd_data_d;
      end
   end

   // Ring storage; a same-cycle read sees the old word since the write lands at the edge.
   always_ff @(posedge clock) begin
      if (ring_we && !reset) begin
         ring_q[wptr_q] <= op_data;
      end
   end

   assign res_valid     = res_valid_q;
   assign res_data      = res_data_q;
   assign res_underflow = res_underflow_q;
   assign rd_data       = rd_data_q;
   assign out_count     = out_count_q;
   assign out_wrapped   = out_wrapped_q;

endmodule

// File: tb/tb_zero_io_channels.sv
// Directed bench for zero_io_channels with default parameters
// (WIDTH 12, NCHAN 2, NIN 8, NOUT 100).
module tb_zero_io_channels;

   logic        clock = 1'b0;
   logic        reset;
   logic        load_valid;
   logic [0:0]  load_chan;
   logic [11:0] load_data;
   logic        load_ready;
   logic        op_valid;
   logic [1:0]  op_code;
   logic [0:0]  op_chan;
   logic [11:0] op_data;
   logic        res_valid;
   logic [11:0] res_data;
   logic        res_underflow;
   logic [6:0]  rd_addr;
   logic [11:0] rd_data;
   logic [6:0]  out_count;
   logic        out_wrapped;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   zero_io_channels dut (
      .clock         (clock),
      .reset         (reset),
      .load_valid    (load_valid),
      .load_chan     (load_chan),
      .load_data     (load_data),
      .load_ready    (load_ready),
      .op_valid      (op_valid),
      .op_code       (op_code),
      .op_chan       (op_chan),
      .op_data       (op_data),
      .res_valid     (res_valid),
      .res_data      (res_data),
      .res_underflow (res_underflow),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .out_count     (out_count),
      .out_wrapped   (out_wrapped)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_load(input logic [0:0] ch, input logic [11:0] d);
      load_valid = 1'b1; load_chan = ch; load_data = d;
      tick();
      load_valid = 1'b0;
   endtask

   task automatic do_op(input logic [1:0] code, input logic [0:0] ch, input logic [11:0] d);
      op_valid = 1'b1; op_code = code; op_chan = ch; op_data = d;
      tick();
      op_valid = 1'b0;
   endtask

   task automatic expect_in(input string tag, input logic [0:0] ch, input logic [11:0] exp);
      do_op(2'd1, ch, 12'd0);
      check({tag, "_valid"}, res_valid, 1);
      check({tag, "_data"}, res_data, exp);
      check({tag, "_uf"}, res_underflow, 0);
   endtask

   task automatic expect_size(input string tag, input logic [0:0] ch, input logic [11:0] exp);
      do_op(2'd2, ch, 12'd0);
      check({tag, "_valid"}, res_valid, 1);
      check({tag, "_data"}, res_data, exp);
   endtask

   task automatic expect_rd(input string tag, input logic [6:0] a, input logic [11:0] exp);
      rd_addr = a;
      tick();
      check(tag, rd_data, exp);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; load_valid = 1'b0; load_chan = '0; load_data = '0;
      op_valid = 1'b0; op_code = 2'd0; op_chan = '0; op_data = '0; rd_addr = '0;
      tick();
      do_reset();

      // Reset state
      check("rst_res_valid", res_valid, 0);
      check("rst_res_data", res_data, 0);
      check("rst_res_uf", res_underflow, 0);
      check("rst_out_count", out_count, 0);
      check("rst_out_wrapped", out_wrapped, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_load_ready", load_ready, 1);

      // FIFO order and INSIZE tracking on ch0
      do_load(1'b0, 12'd33);
      do_load(1'b0, 12'd22);
      do_load(1'b0, 12'd11);
      expect_size("sz3", 1'b0, 12'd3);
      expect_in("in33", 1'b0, 12'd33);
      expect_size("sz2", 1'b0, 12'd2);
      expect_in("in22", 1'b0, 12'd22);
      expect_size("sz1", 1'b0, 12'd1);
      expect_in("in11", 1'b0, 12'd11);
      expect_size("sz0", 1'b0, 12'd0);

      // Underflow on empty channel, then result pulse drops
      do_op(2'd1, 1'b0, 12'd0);
      check("uf_valid", res_valid, 1);
      check("uf_flag", res_underflow, 1);
      check("uf_data", res_data, 0);
      expect_size("uf_sz", 1'b0, 12'd0);
      check("uf_sz_flag", res_underflow, 0);
      tick();
      check("pulse_low", res_valid, 0);

      // NOP produces no result
      do_op(2'd0, 1'b0, 12'd0);
      check("nop_valid", res_valid, 0);

      // Fill ch1 past capacity: ninth load dropped
      for (int i = 0; i < 9; i++) begin
         load_valid = 1'b1; load_chan = 1'b1; load_data = 12'(100 + i);
         #1;
         check($sformatf("ld_ready_%0d", i), load_ready, (i < 8) ? 1 : 0);
         tick();
      end
      load_valid = 1'b0;
      expect_size("full_sz", 1'b1, 12'd8);
      for (int i = 0; i < 8; i++) begin
         expect_in($sformatf("drain_%0d", i), 1'b1, 12'(100 + i));
      end
      expect_size("ch1_empty", 1'b1, 12'd0);
      expect_size("ch0_untouched", 1'b0, 12'd0);

      // Output ring basics
      do_op(2'd3, 1'b0, 12'd1);
      do_op(2'd3, 1'b0, 12'd2);
      do_op(2'd3, 1'b0, 12'd3);
      check("out3_count", out_count, 3);
      check("out3_wrapped", out_wrapped, 0);
      check("out_no_result", res_valid, 0);
      expect_rd("rd0", 7'd0, 12'd1);
      expect_rd("rd1", 7'd1, 12'd2);
      expect_rd("rd2", 7'd2, 12'd3);

      // Wrap: 101 writes into a 100-entry ring
      do_reset();
      for (int i = 0; i < 100; i++) do_op(2'd3, 1'b0, 12'(i));
      check("w100_count", out_count, 100);
      check("w100_wrapped", out_wrapped, 1);
      do_op(2'd3, 1'b0, 12'd100);
      check("w101_count", out_count, 100);
      check("w101_wrapped", out_wrapped, 1);
      expect_rd("wrap_rd0", 7'd0, 12'd100);
      expect_rd("wrap_rd1", 7'd1, 12'd1);
      expect_rd("wrap_rd99", 7'd99, 12'd99);

      // Read of the address being written returns the old word
      rd_addr = 7'd1;
      do_op(2'd3, 1'b0, 12'd555);
      check("rw_same_old", rd_data, 1);
      expect_rd("rw_same_new", 7'd1, 12'd555);

      // Simultaneous load and IN on ch0 holding two words
      do_reset();
      do_load(1'b0, 12'd5);
      do_load(1'b0, 12'd6);
      load_valid = 1'b1; load_chan = 1'b0; load_data = 12'd7;
      do_op(2'd1, 1'b0, 12'd0);
      load_valid = 1'b0;
      check("sim_in_data", res_data, 5);
      expect_size("sim_sz", 1'b0, 12'd2);
      expect_in("sim_in6", 1'b0, 12'd6);
      expect_in("sim_in7", 1'b0, 12'd7);

      // Load and IN on an empty channel: underflow, load still lands
      load_valid = 1'b1; load_chan = 1'b0; load_data = 12'd44;
      do_op(2'd1, 1'b0, 12'd0);
      load_valid = 1'b0;
      check("sim_empty_uf", res_underflow, 1);
      check("sim_empty_data", res_data, 0);
      expect_size("sim_empty_sz", 1'b0, 12'd1);

      // Full channel: load dropped even though IN frees a slot
      for (int i = 0; i < 8; i++) do_load(1'b1, 12'(200 + i));
      load_valid = 1'b1; load_chan = 1'b1; load_data = 12'd999;
      #1;
      check("full_ready", load_ready, 0);
      do_op(2'd1, 1'b1, 12'd0);
      load_valid = 1'b0;
      check("full_in_data", res_data, 200);
      expect_size("full_in_sz", 1'b1, 12'd7);
      do_op(2'd3, 1'b0, 12'd9);
      check("pre_rst_count", out_count, 1);

      // Reset mid-stream with an op and a load in the same cycle
      reset = 1'b1;
      load_valid = 1'b1; load_chan = 1'b0; load_data = 12'd88;
      do_op(2'd2, 1'b1, 12'd0);
      load_valid = 1'b0;
      reset = 1'b0;
      check("mid_rst_valid", res_valid, 0);
      check("mid_rst_count", out_count, 0);
      check("mid_rst_wrapped", out_wrapped, 0);
      expect_size("mid_rst_sz0", 1'b0, 12'd0);
      expect_size("mid_rst_sz1", 1'b1, 12'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
